led_scan_arbiter: RTL and testbench

LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

---
 rtl/led_scan_arbiter.sv | 115 +++++++++++
 tb/tb_led_scan_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led_scan_arbiter.sv
// Two-requester arbiter for an 8-digit multiplexed 7-segment display.
// The owner keeps the display for at least MIN_FRAMES full scans before the other side can take it.
module led_scan_arbiter #(
  parameter int SCAN_DIV   = 100000,
  parameter int MIN_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [7:0]  en,
  output logic [7:0]  cx
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(MIN_FRAMES + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [FW:0]   MINF    = (FW+1)'(MIN_FRAMES);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state;
  logic          last_b;     // 1 when B was the most recent owner
  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;

  logic          owned, div_wrap, frame_end, quota, own_req, oth_req;
  logic [FW:0]   fc_inc;
  logic [31:0]   odata;
  logic [3:0]    nib;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  assign owned     = (state != IDLE);
  assign div_wrap  = (div_cnt == DIV_MAX);
  assign frame_end = div_wrap && (idx == 3'd7);
  assign fc_inc    = {1'b0, frame_cnt} + 1'b1;
  assign quota     = (fc_inc >= MINF);
  assign own_req   = (state == OWN_B) ? req_b : req_a;
  assign oth_req   = (state == OWN_B) ? req_a : req_b;
  assign odata     = (state == OWN_B) ? data_b : data_a;
  assign nib       = odata[{idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      last_b    <= 1'b1;
      div_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      en        <= 8'hFF;
      cx        <= 8'hFF;
    end else begin
      en <= owned ? ~(8'h01 << idx) : 8'hFF;
      cx <= owned ? hex7(nib) : 8'hFF;
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          idx       <= '0;
          frame_cnt <= '0;
          if (req_a && (!req_b || last_b)) begin
            state   <= OWN_A;
            grant_a <= 1'b1;
            last_b  <= 1'b0;
          end else if (req_b) begin
            state   <= OWN_B;
            grant_b <= 1'b1;
            last_b  <= 1'b1;
          end
        end
        OWN_A, OWN_B: begin
          if (!own_req) begin
            state     <= IDLE;
            grant_a   <= 1'b0;
            grant_b   <= 1'b0;
            div_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
          end else if (frame_end && oth_req && quota) begin
            // direct hand-over, scan restarts at digit 0 for the new owner
            state     <= (state == OWN_A) ? OWN_B : OWN_A;
            grant_a   <= (state == OWN_B);
            grant_b   <= (state == OWN_A);
            last_b    <= (state == OWN_A);
            div_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
          end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) idx <= idx + 3'd1;
            if (frame_end) frame_cnt <= quota ? MINF[FW-1:0] : fc_inc[FW-1:0];
          end
        end
        default: begin
          state   <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_scan_arbiter.sv
// Bench for led_scan_arbiter: cycle-elapsed model compared every cycle, plus literal spot checks.
module tb_led_scan_arbiter;
  localparam int SD  = 4;
  localparam int MF  = 2;
  localparam int PER = 8 * SD;

  logic        clk = 1'b0, rst = 1'b1, req_a = 1'b0, req_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        grant_a, grant_b;
  logic [7:0]  en, cx;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [7:0] ENS [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  always #5 clk = ~clk;

  led_scan_arbiter #(.SCAN_DIV(SD), .MIN_FRAMES(MF)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .grant_a(grant_a), .grant_b(grant_b), .en(en), .cx(cx)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: owner 0=none 1=A 2=B; m_t = cycles elapsed since the current grant.
  int         m_owner = 0, m_last = 2, m_t = 0;
  logic [7:0] m_en = 8'hFF, m_cx = 8'hFF;
  bit         go = 1'b0;

  always @(posedge clk) begin : model
    int pos, didx, oreq, xreq;
    logic [31:0] d;
    logic [3:0]  nb;
    if (rst) begin
      m_owner = 0; m_last = 2; m_t = 0; m_en = 8'hFF; m_cx = 8'hFF; go = 1'b1;
    end else begin
      pos  = m_t % PER;
      didx = pos / SD;
      d    = (m_owner == 2) ? data_b : data_a;
      nb   = 4'(d >> (4 * didx));
      m_en = (m_owner == 0) ? 8'hFF : ~(8'h01 << didx);
      m_cx = (m_owner == 0) ? 8'hFF : HEX[nb];
      if (m_owner == 0) begin
        m_t = 0;
        if (req_a && (!req_b || m_last == 2)) begin m_owner = 1; m_last = 1; end
        else if (req_b) begin m_owner = 2; m_last = 2; end
      end else begin
        oreq = (m_owner == 1) ? int'(req_a) : int'(req_b);
        xreq = (m_owner == 1) ? int'(req_b) : int'(req_a);
        if (oreq == 0) begin
          m_owner = 0; m_t = 0;
        end else if (pos == PER - 1 && xreq != 0 && (m_t / PER) + 1 >= MF) begin
          m_owner = 3 - m_owner; m_last = m_owner; m_t = 0;
        end else begin
          m_t++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("model_grant_a", 8'(grant_a), 8'(m_owner == 1));
      chk("model_grant_b", 8'(grant_b), 8'(m_owner == 2));
      chk("model_en", en, m_en);
      chk("model_cx", cx, m_cx);
    end
  end

  initial begin
    // reset with both requests pending, then tie goes to A
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    repeat (2) begin
      step(1);
      chk("rst_grant_a", 8'(grant_a), 8'h00);
      chk("rst_grant_b", 8'(grant_b), 8'h00);
      chk("rst_en", en, 8'hFF);
      chk("rst_cx", cx, 8'hFF);
    end
    rst = 1'b0;
    step(1); chk("tie_a", 8'(grant_a), 8'h01);
    req_a = 1'b0;
    step(1); chk("rel_idle_a", 8'(grant_a), 8'h00); chk("rel_idle_b", 8'(grant_b), 8'h00);
    step(1); chk("rot_b", 8'(grant_b), 8'h01);

    // scan pattern over two frames
    rst = 1'b1; req_b = 1'b0; req_a = 1'b1; data_a = 32'h76543210;
    step(1); rst = 1'b0;
    step(1); chk("scan_grant", 8'(grant_a), 8'h01);
    step(1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step(4);
      chk("scan_en", en, ENS[k % 8]);
      chk("scan_cx", cx, HEX[k % 8]);
    end

    // preemption at end of frame 2
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; data_b = 32'hFEDCBA98;
    step(1); rst = 1'b0;
    step(1);
    step(5); req_b = 1'b1;
    step(58); chk("pre_hold_a", 8'(grant_a), 8'h01);
    step(1);  chk("pre_drop_a", 8'(grant_a), 8'h00); chk("pre_take_b", 8'(grant_b), 8'h01);
    step(1);  chk("pre_en", en, 8'hFE); chk("pre_cx", cx, 8'h80);

    // competing pulse between frame ends is ignored; later a saturated owner yields at next frame end
    req_a = 1'b0;
    step(39); req_a = 1'b1;
    step(10); req_a = 1'b0;
    step(14); chk("pulse_ignored", 8'(grant_b), 8'h01);
    step(100); req_a = 1'b1;
    step(27); chk("sat_hold_b", 8'(grant_b), 8'h01);
    step(1);  chk("sat_take_a", 8'(grant_a), 8'h01);
    req_b = 1'b0;

    // mid-frame release
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0;
    step(1); rst = 1'b0;
    step(1);
    step(10); req_a = 1'b0;
    step(1); chk("mid_rel_grant", 8'(grant_a), 8'h00); chk("mid_rel_en", en, 8'hFB);
    step(1); chk("mid_rel_en_off", en, 8'hFF); chk("mid_rel_cx_off", cx, 8'hFF);

    // last owner was A, so a tie now goes to B
    req_a = 1'b1; req_b = 1'b1;
    step(1); chk("tie_rot_b", 8'(grant_b), 8'h01);

    // live data change, then reset while B scans digit 3
    step(5); data_b = 32'h000000A0;
    step(1); chk("live_cx", cx, 8'h88);
    step(7); rst = 1'b1;
    step(1);
    chk("mrst_grant_a", 8'(grant_a), 8'h00);
    chk("mrst_grant_b", 8'(grant_b), 8'h00);
    chk("mrst_en", en, 8'hFF);
    chk("mrst_cx", cx, 8'hFF);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    step(3); chk("post_rst_idle", 8'(grant_a | grant_b), 8'h00);

    // soak: sparse request toggling checked by the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) req_a = ~req_a;
      if ($urandom_range(0, 39) == 0) req_b = ~req_b;
      if ($urandom_range(0, 15) == 0) data_a = $urandom;
      if ($urandom_range(0, 15) == 0) data_b = $urandom;
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
